// File: rtl/seg7_scan_decoder_if.sv
// Bundle of display lines (toward the decoder) and recovered-digit status (from it).
// Macro SEG7_SCAN_DEC_HEX_EN (see decoder) does not change this interface.
interface seg7_scan_if #(
    parameter int DIGITS = 8
);
    logic [DIGITS-1:0]   an_i;
    logic [6:0]          seg_i;
    logic [4*DIGITS-1:0] digits_o;
    logic [DIGITS-1:0]   valid_o;
    logic [DIGITS-1:0]   blank_o;
    logic                upd_o;
    logic [3:0]          upd_idx_o;
    logic                err_o;
    logic                frame_o;
    logic [1:0]          state_o;

    // Handshake: upd_o is a one-cycle strobe with no backpressure; upd_idx_o, err_o and
    // frame_o are qualified by it, digits_o/valid_o/blank_o are level outputs.
    modport master (
        output an_i, seg_i,
        input  digits_o, valid_o, blank_o, upd_o, upd_idx_o, err_o, frame_o, state_o
    );
    modport slave (
        input  an_i, seg_i,
        output digits_o, valid_o, blank_o, upd_o, upd_idx_o, err_o, frame_o, state_o
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Reader for a multiplexed active-low 7-segment display: recovers per-digit values and status.
// Define SEG7_SCAN_DEC_HEX_EN to also recognize the A-F glyphs.
module seg7_scan_decoder #(
    parameter int DIGITS      = 8,
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    seg7_scan_if.slave  bus
);
    localparam int CW = (STABLE_CYC < 2) ? 1 : $clog2(STABLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, COMMIT = 2'd2, HOLD = 2'd3} state_t;

    state_t state, state_nx;
    logic [DIGITS-1:0]   an_m, an_s, cand_an;
    logic [6:0]          seg_m, seg_s, cand_seg;
    logic [CW-1:0]       cnt;
    logic [TW-1:0]       tmo;
    logic [DIGITS-1:0]   seen, seen_nx;
    logic [4*DIGITS-1:0] digits;
    logic [DIGITS-1:0]   valid, blank;
    logic                upd, err, frame;
    logic [3:0]          upd_idx, cidx;
    logic                sel_ok, same, load, inc, commit;
    logic [4:0]          dec;

    function automatic logic [4:0] decode(input logic [6:0] s);
        // {recognized, value}
        case (s)
            7'b1000000: decode = 5'h10;
            7'b1111001: decode = 5'h11;
            7'b0100100: decode = 5'h12;
            7'b0110000: decode = 5'h13;
            7'b0011001: decode = 5'h14;
            7'b0010010: decode = 5'h15;
            7'b0000010: decode = 5'h16;
            7'b1111000: decode = 5'h17;
            7'b0000000: decode = 5'h18;
            7'b0010000: decode = 5'h19;
`ifdef SEG7_SCAN_DEC_HEX_EN
            7'b0001000: decode = 5'h1A;
            7'b0000011: decode = 5'h1B;
            7'b1000110: decode = 5'h1C;
            7'b0100001: decode = 5'h1D;
            7'b0000110: decode = 5'h1E;
            7'b0001110: decode = 5'h1F;
`endif
            default:    decode = 5'h00;
        endcase
    endfunction

    // Sync flops reset to all-ones so the display reads as off.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            an_m  <= '1;
            an_s  <= '1;
            seg_m <= '1;
            seg_s <= '1;
        end else begin
            an_m  <= bus.an_i;
            an_s  <= an_m;
            seg_m <= bus.seg_i;
            seg_s <= seg_m;
        end
    end

    always_comb begin
        sel_ok = $onehot(~an_s);
        same   = (an_s == cand_an) && (seg_s == cand_seg);
        commit = (state == COMMIT);
        cidx   = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (!cand_an[k]) cidx = 4'(k);
        end
        dec     = decode(cand_seg);
        seen_nx = seen | (DIGITS'(1) << cidx);
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        inc      = 1'b0;
        case (state)
            IDLE: begin
                if (sel_ok) begin
                    load     = 1'b1;
                    state_nx = (STABLE_CYC == 1) ? COMMIT : SETTLE;
                end
            end
            SETTLE: begin
                if (!sel_ok) begin
                    state_nx = IDLE;
                end else if (!same) begin
                    load = 1'b1;
                end else begin
                    inc = 1'b1;
                    if (cnt == CW'(STABLE_CYC - 1)) state_nx = COMMIT;
                end
            end
            COMMIT: state_nx = HOLD;
            HOLD: begin
                // Only a change of the window leaves HOLD, so one window commits once.
                if (!same) begin
                    if (sel_ok) begin
                        load     = 1'b1;
                        state_nx = (STABLE_CYC == 1) ? COMMIT : SETTLE;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= IDLE;
            cand_an  <= '1;
            cand_seg <= '1;
            cnt      <= '0;
        end else begin
            state <= state_nx;
            if (load) begin
                cand_an  <= an_s;
                cand_seg <= seg_s;
                cnt      <= CW'(1);
            end else if (inc) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            digits  <= '0;
            valid   <= '0;
            blank   <= '0;
            seen    <= '0;
            tmo     <= '0;
            upd     <= 1'b0;
            upd_idx <= 4'd0;
            err     <= 1'b0;
            frame   <= 1'b0;
        end else begin
            upd   <= commit;
            err   <= 1'b0;
            frame <= 1'b0;
            if (commit) begin
                tmo <= '0;
            end else if (tmo != TW'(TIMEOUT_CYC)) begin
                tmo <= tmo + TW'(1);
            end
            if (commit) begin
                upd_idx <= cidx;
                if (dec[4]) begin
                    digits[int'(cidx)*4 +: 4] <= dec[3:0];
                    valid[cidx] <= 1'b1;
                    blank[cidx] <= 1'b0;
                end else if (cand_seg == SEG_OFF) begin
                    valid[cidx] <= 1'b0;
                    blank[cidx] <= 1'b1;
                end else begin
                    valid[cidx] <= 1'b0;
                    blank[cidx] <= 1'b0;
                    err         <= 1'b1;
                end
                if (&seen_nx) begin
                    frame <= 1'b1;
                    seen  <= '0;
                end else begin
                    seen <= seen_nx;
                end
            end else if (tmo == TW'(TIMEOUT_CYC - 1)) begin
                // Stale display: drop status once on entering saturation, keep last values.
                valid <= '0;
                blank <= '0;
                seen  <= '0;
            end
        end
    end

    assign bus.digits_o  = digits;
    assign bus.valid_o   = valid;
    assign bus.blank_o   = blank;
    assign bus.upd_o     = upd;
    assign bus.upd_idx_o = upd_idx;
    assign bus.err_o     = err;
    assign bus.frame_o   = frame;
    assign bus.state_o   = state;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios plus random segment streams vs a segment-level model.
// Build with SEG7_SCAN_DEC_HEX_EN defined to check the A-F variant.
module tb_seg7_scan_decoder;
    localparam int DIGITS = 8;
    localparam int STABLE = 4;
    localparam int TMO    = 300;
`ifdef SEG7_SCAN_DEC_HEX_EN
    localparam int NREC = 16;
`else
    localparam int NREC = 10;
`endif

    typedef struct packed {
        logic [31:0] edge_n;
        logic [3:0]  idx;
        logic        err;
        logic        frame;
        logic [31:0] digits;
        logic [7:0]  valid;
        logic [7:0]  blank;
    } rec_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_if #(.DIGITS(DIGITS)) bus ();
    seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYC(STABLE), .TIMEOUT_CYC(TMO)) dut (
        .clk_i (clk),
        .rstn_i(rstn),
        .bus   (bus)
    );

    logic [6:0] pat_tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    int total = 0;
    int bad = 0;
    int edge_cnt = 0;
    rec_t exp_q[$];

    logic [31:0] m_digits;
    logic [7:0]  m_valid, m_blank, m_seen;
    int m_last, m_skip, drive_edge;
    logic [7:0] cur_an;
    logic [6:0] cur_seg;

    int upd_cnt = 0, err_cnt = 0, frame_cnt = 0;
    int last_idx = 0, last_upd_edge = 0, last_frame_edge = -1;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    // Model: one commit per constant input segment whose usable length reaches STABLE.
    task automatic model_commit(input logic [7:0] an, input logic [6:0] seg, input int e);
        rec_t r;
        int idx, val;
        bit found;
        if (e > m_last + TMO) begin
            m_valid = '0;
            m_blank = '0;
            m_seen  = '0;
        end
        idx = 0;
        for (int i = 0; i < DIGITS; i++) if (!an[i]) idx = i;
        found = 1'b0;
        val = 0;
        for (int i = 0; i < NREC; i++) if (pat_tbl[i] == seg) begin found = 1'b1; val = i; end
        r.err = 1'b0;
        if (found) begin
            m_digits[idx*4 +: 4] = 4'(val);
            m_valid[idx] = 1'b1;
            m_blank[idx] = 1'b0;
        end else if (seg == 7'h7F) begin
            m_valid[idx] = 1'b0;
            m_blank[idx] = 1'b1;
        end else begin
            m_valid[idx] = 1'b0;
            m_blank[idx] = 1'b0;
            r.err = 1'b1;
        end
        m_seen[idx] = 1'b1;
        r.frame = (m_seen == 8'hFF);
        if (r.frame) m_seen = '0;
        m_last   = e;
        r.edge_n = 32'(e);
        r.idx    = 4'(idx);
        r.digits = m_digits;
        r.valid  = m_valid;
        r.blank  = m_blank;
        exp_q.push_back(r);
    endtask

    task automatic drive_seg(input logic [7:0] an, input logic [6:0] seg, input int len);
        int s;
        @(negedge clk);
        bus.an_i = an;
        bus.seg_i = seg;
        cur_an = an;
        cur_seg = seg;
        drive_edge = edge_cnt;
        s = edge_cnt + 1;
        if ($onehot(~an) && (len - m_skip >= STABLE)) begin
            model_commit(an, seg, s + m_skip + 2 + STABLE);
            // A commit landing on the next segment's first sample makes that sample unusable.
            m_skip = (len - m_skip == STABLE) ? 1 : 0;
        end else begin
            m_skip = 0;
        end
        repeat (len - 1) @(negedge clk);
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        bus.an_i = '1;
        bus.seg_i = '1;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        exp_q.delete();
        m_digits = '0;
        m_valid = '0;
        m_blank = '0;
        m_seen = '0;
        m_last = edge_cnt;
        m_skip = 0;
        cur_an = '1;
        cur_seg = '1;
    endtask

    task automatic scen1(input string tag);
        int u0, e0, d;
        u0 = upd_cnt;
        e0 = err_cnt;
        drive_seg(8'hFE, 7'b0110000, 10);
        d = drive_edge;
        drive_seg(8'hFF, 7'h7F, 6);
        check({tag, "_upd_count"}, 64'(upd_cnt - u0), 1);
        check({tag, "_latency"}, 64'(last_upd_edge - d), 7);
        check({tag, "_idx"}, 64'(last_idx), 0);
        check({tag, "_digit0"}, 64'(bus.digits_o[3:0]), 3);
        check({tag, "_valid"}, 64'(bus.valid_o), 8'h01);
        check({tag, "_err"}, 64'(err_cnt - e0), 0);
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (exp_q.size() > 0 && int'(exp_q[0].edge_n) < edge_cnt) begin
                check("upd_missing", 0, 1);
                void'(exp_q.pop_front());
            end
            if (bus.upd_o) begin
                rec_t r;
                upd_cnt++;
                last_idx = int'(bus.upd_idx_o);
                last_upd_edge = edge_cnt;
                if (bus.err_o) err_cnt++;
                if (bus.frame_o) begin frame_cnt++; last_frame_edge = edge_cnt; end
                if (exp_q.size() == 0) begin
                    check("upd_spurious", 1, 0);
                end else begin
                    r = exp_q.pop_front();
                    check("upd_edge", 64'(edge_cnt), 64'(r.edge_n));
                    check("upd_idx", 64'(bus.upd_idx_o), 64'(r.idx));
                    check("err", 64'(bus.err_o), 64'(r.err));
                    check("frame", 64'(bus.frame_o), 64'(r.frame));
                    check("digits", 64'(bus.digits_o), 64'(r.digits));
                    check("valid", 64'(bus.valid_o), 64'(r.valid));
                    check("blank", 64'(bus.blank_o), 64'(r.blank));
                end
            end else if (bus.err_o || bus.frame_o) begin
                check("orphan_pulse", 64'({bus.err_o, bus.frame_o}), 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (edge %0d)", edge_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int u0, e0, f0;
        logic [7:0] an;
        logic [6:0] seg;
        apply_reset();
        check("rst_digits", 64'(bus.digits_o), 0);
        check("rst_valid", 64'(bus.valid_o), 0);
        check("rst_blank", 64'(bus.blank_o), 0);
        check("rst_pulses", 64'({bus.upd_o, bus.err_o, bus.frame_o}), 0);
        check("rst_state", 64'(bus.state_o), 0);

        scen1("s1");

        f0 = frame_cnt;
        for (int k = 0; k < 8; k++) begin
            drive_seg(8'hFF, 7'h7F, 2);
            drive_seg(~(8'd1 << k), pat_tbl[k], 20);
        end
        drive_seg(8'hFF, 7'h7F, 10);
        check("s2_digits", 64'(bus.digits_o), 32'h76543210);
        check("s2_valid", 64'(bus.valid_o), 8'hFF);
        check("s2_frames", 64'(frame_cnt - f0), 1);
        check("s2_frame_at_d7", 64'(last_frame_edge), 64'(last_upd_edge));
        check("s2_last_idx", 64'(last_idx), 7);

        u0 = upd_cnt;
        for (int i = 0; i < 10; i++) drive_seg(8'hFB, pat_tbl[8 + (i % 2)], 3);
        drive_seg(8'hFB, pat_tbl[2], 6);
        drive_seg(8'hFF, 7'h7F, 10);
        check("s3_commits", 64'(upd_cnt - u0), 1);
        check("s3_idx", 64'(last_idx), 2);

        e0 = err_cnt;
        drive_seg(8'hFD, 7'b0001000, 20);
        drive_seg(8'hFF, 7'h7F, 10);
`ifdef SEG7_SCAN_DEC_HEX_EN
        check("s4_hex_digit", 64'(bus.digits_o[7:4]), 4'hA);
        check("s4_hex_valid", 64'(bus.valid_o[1]), 1);
`else
        check("s4_hex_err", 64'(err_cnt - e0), 1);
        check("s4_hex_valid", 64'(bus.valid_o[1]), 0);
`endif
        drive_seg(8'hFD, 7'h7F, 20);
        drive_seg(8'hFF, 7'h7F, 10);
        check("s4_blank", 64'(bus.blank_o[1]), 1);
        check("s4_blank_valid", 64'(bus.valid_o[1]), 0);

        u0 = upd_cnt;
        drive_seg(8'hFC, pat_tbl[5], 50);
        check("s5_no_commit", 64'(upd_cnt - u0), 0);
        drive_seg(8'hFF, 7'h7F, TMO + 10);
        check("s5_tmo_valid", 64'(bus.valid_o), 0);
        check("s5_tmo_blank", 64'(bus.blank_o), 0);
        check("s5_tmo_digits", 64'(bus.digits_o), 64'(m_digits));

        @(negedge clk);
        bus.an_i = 8'hFE;
        bus.seg_i = 7'b0110000;
        repeat (4) @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check("s6_digits", 64'(bus.digits_o), 0);
        check("s6_valid", 64'(bus.valid_o), 0);
        check("s6_blank", 64'(bus.blank_o), 0);
        check("s6_idx", 64'(bus.upd_idx_o), 0);
        check("s6_pulses", 64'({bus.upd_o, bus.err_o, bus.frame_o}), 0);
        check("s6_state", 64'(bus.state_o), 0);
        apply_reset();
        scen1("s6r");

        for (int n = 0; n < 150; n++) begin
            do begin
                int kind, sk, i, j;
                kind = $urandom_range(0, 9);
                if (kind <= 6) begin
                    an = ~(8'd1 << $urandom_range(0, 7));
                end else if (kind == 7) begin
                    i = $urandom_range(0, 7);
                    j = (i + 1 + $urandom_range(0, 6)) % 8;
                    an = ~((8'd1 << i) | (8'd1 << j));
                end else begin
                    an = 8'hFF;
                end
                sk = $urandom_range(0, 9);
                if (sk <= 5) seg = pat_tbl[$urandom_range(0, 15)];
                else if (sk == 6) seg = 7'h7F;
                else seg = 7'($urandom);
            end while (an == cur_an && seg == cur_seg);
            drive_seg(an, seg, $urandom_range(2, 12));
        end
        drive_seg(8'hFF, 7'h7F, 20);
        check("queue_drained", 64'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
